// File: rtl/fruta_gen.sv
// Fruit-position generator: on a request edge, draws an in-map cell from a free-running LFSR
// using per-axis rejection sampling, then pulses fruta_wenable with the new coordinates.
module fruta_gen #(
   parameter int unsigned MAPA_WIDTH  = 40,
   parameter int unsigned MAPA_HEIGHT = 30,
   parameter logic [15:0] SEED        = 16'hACE1,
   parameter int unsigned MAX_TRIES   = 32,
   parameter int unsigned INIT_X      = 15,
   parameter int unsigned INIT_Y      = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fruta_enable,
   output logic       fruta_wenable,
   output logic [9:0] fruta_wx,
   output logic [9:0] fruta_wy,
   output logic       busy
);

   localparam int unsigned XW       = $clog2(MAPA_WIDTH);
   localparam int unsigned YW       = $clog2(MAPA_HEIGHT);
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
   localparam logic [9:0]  W10      = 10'(MAPA_WIDTH);
   localparam logic [9:0]  H10      = 10'(MAPA_HEIGHT);
   localparam logic [7:0]  MT8      = 8'(MAX_TRIES);
   localparam logic [9:0]  INIT_X10 = 10'(INIT_X);
   localparam logic [9:0]  INIT_Y10 = 10'(INIT_Y);

   typedef enum logic [1:0] {StIdle, StDrawX, StDrawY, StDone} state_e;

   state_e      state_q, state_d;
   logic [15:0] lfsr_q;
   logic        req_q;
   logic        pending_q, pending_d;
   logic [7:0]  tries_q, tries_d;
   logic [9:0]  x_q, x_d;
   logic [9:0]  wx_q, wx_d, wy_q, wy_d;
   logic        wen_q, wen_d;
   logic        busy_q, busy_d;
   logic        req_edge;
   logic [9:0]  cx, cy;

   assign req_edge = fruta_enable & ~req_q;

   // Candidate fields of the current LFSR value; y wraps around the register for tall maps.
   always_comb begin
      cx = '0;
      cy = '0;
      for (int unsigned i = 0; i < XW; i++) cx[i] = lfsr_q[i % 16];
      for (int unsigned i = 0; i < YW; i++) cy[i] = lfsr_q[(i + 8) % 16];
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      tries_d   = tries_q;
      x_d       = x_q;
      wx_d      = wx_q;
      wy_d      = wy_q;
      wen_d     = 1'b0;
      busy_d    = busy_q;
      unique case (state_q)
         StIdle: begin
            if (req_edge) begin
               state_d = StDrawX;
               busy_d  = 1'b1;
               tries_d = '0;
            end
         end
         StDrawX: begin
            if (req_edge) pending_d = 1'b1;
            if (cx < W10 || tries_q + 8'd1 == MT8) begin
               // Out-of-range fallback folds once; 2^XW < 2*MAPA_WIDTH keeps it legal.
               x_d     = (cx < W10) ? cx : cx - W10;
               tries_d = '0;
               state_d = StDrawY;
            end else begin
               tries_d = tries_q + 8'd1;
            end
         end
         StDrawY: begin
            if (req_edge) pending_d = 1'b1;
            if (cy < H10 || tries_q + 8'd1 == MT8) begin
               wx_d    = x_q;
               wy_d    = (cy < H10) ? cy : cy - H10;
               wen_d   = 1'b1;
               busy_d  = 1'b0;
               tries_d = '0;
               state_d = StDone;
            end else begin
               tries_d = tries_q + 8'd1;
            end
         end
         StDone: begin
            // An edge arriving in this cycle behaves like an already-pending request.
            if (pending_q || req_edge) begin
               pending_d = 1'b0;
               busy_d    = 1'b1;
               tries_d   = '0;
               state_d   = StDrawX;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         lfsr_q    <= SEED_EFF;
         req_q     <= 1'b0;
         pending_q <= 1'b0;
         tries_q   <= '0;
         x_q       <= '0;
         wx_q      <= INIT_X10;
         wy_q      <= INIT_Y10;
         wen_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
         req_q     <= fruta_enable;
         pending_q <= pending_d;
         tries_q   <= tries_d;
         x_q       <= x_d;
         wx_q      <= wx_d;
         wy_q      <= wy_d;
         wen_q     <= wen_d;
         busy_q    <= busy_d;
      end
   end

   assign fruta_wenable = wen_q;
   assign fruta_wx      = wx_q;
   assign fruta_wy      = wy_q;
   assign busy          = busy_q;

endmodule
